// File: rtl/pu_pkg.sv
// Shared types and sizing constants for the img2col PU window loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pu_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int ADDR_WIDTH    = 5;
  localparam int ROUND_WIDTH   = 6;
  localparam int WEIGHT_SIZE   = 25;
  localparam int COL_SIZE      = 5;
  localparam int COL_BASE_ADDR = WEIGHT_SIZE - COL_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FULL_LOAD,
    ST_COL_LOAD,
    ST_LAUNCH,
    ST_WAIT_PU,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/pu_window_loader.sv
// Feeds one PU's 25-entry register file from the pixel stream and launches each round.
// Latency: a beat is written 1 cycle after acceptance; start follows the last write by 1 cycle.
// Backpressure: s_ready is high only while a load still needs words; low in launch/wait/idle.
module pu_window_loader
  import pu_pkg::*;
#(
  parameter int data_width  = DATA_WIDTH,
  parameter int weight_size = WEIGHT_SIZE,
  parameter int col_size    = COL_SIZE,
  parameter int address_num = ADDR_WIDTH,
  parameter int round_width = ROUND_WIDTH
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   go,
  input  logic [round_width-1:0] num_rounds,
  input  logic [data_width-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   pu_done,
  output logic [data_width-1:0]  new1,
  output logic [address_num-1:0] adrs_in1,
  output logic [address_num-1:0] adrs_in2,
  output logic                   wr_ctrl_g,
  output logic                   start,
  output logic [round_width-1:0] round,
  output logic                   busy,
  output logic                   done
);

  localparam logic [address_num-1:0] FULL_LAST = address_num'(weight_size - 1);
  localparam logic [address_num-1:0] COL_LAST  = address_num'(col_size - 1);
  localparam logic [address_num-1:0] COL_BASE  = address_num'(weight_size - col_size);

  state_e                 state_q, state_d;
  logic [address_num-1:0] cnt_q, cnt_d;
  // Set on the final beat of a load so the cycle presenting that write
  // closes the handshake before LAUNCH; avoids wrapping the word counter.
  logic                   last_q, last_d;
  logic [round_width-1:0] round_q, round_d;
  logic [round_width-1:0] rounds_q, rounds_d;
  logic [data_width-1:0]  new1_q, new1_d;
  logic [address_num-1:0] adrs1_q, adrs1_d;
  logic [address_num-1:0] adrs2_q, adrs2_d;
  logic                   wr_q, wr_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      round_q  <= '0;
      rounds_q <= '0;
      new1_q   <= '0;
      adrs1_q  <= '0;
      adrs2_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      round_q  <= round_d;
      rounds_q <= rounds_d;
      new1_q   <= new1_d;
      adrs1_q  <= adrs1_d;
      adrs2_q  <= adrs2_d;
      wr_q     <= wr_d;
    end
  end

  // Next-state, write capture and state-decoded handshake/launch outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    round_d  = round_q;
    rounds_d = rounds_q;
    new1_d   = new1_q;
    adrs1_d  = adrs1_q;
    adrs2_d  = adrs2_q;
    wr_d     = 1'b0;
    s_ready  = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          rounds_d = (num_rounds == '0) ? round_width'(1) : num_rounds;
          round_d  = '0;
          cnt_d    = '0;
          last_d   = 1'b0;
          state_d  = ST_FULL_LOAD;
        end
      end

      ST_FULL_LOAD, ST_COL_LOAD: begin
        if (last_q) begin
          state_d = ST_LAUNCH;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            wr_d    = 1'b1;
            new1_d  = s_data;
            adrs1_d = (state_q == ST_COL_LOAD) ? (COL_BASE + cnt_q) : cnt_q;
            adrs2_d = adrs1_q;
            if (cnt_q == ((state_q == ST_COL_LOAD) ? COL_LAST : FULL_LAST)) begin
              last_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      ST_LAUNCH: begin
        start   = 1'b1;
        state_d = ST_WAIT_PU;
      end

      ST_WAIT_PU: begin
        if (pu_done) begin
          if (round_q == rounds_q - 1'b1) begin
            state_d = ST_FINISH;
          end else begin
            round_d = round_q + 1'b1;
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = ST_COL_LOAD;
          end
        end
      end

      ST_FINISH: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign new1      = new1_q;
  assign adrs_in1  = adrs1_q;
  assign adrs_in2  = adrs2_q;
  assign wr_ctrl_g = wr_q;
  assign round     = round_q;

endmodule

// File: tb/tb_pu_window_loader.sv
// Directed bench for pu_window_loader with a write/launch scoreboard.
// Latency: checks each write, start and done on the cycle it is visible.
// Backpressure: drives s_valid with stalls and honours s_ready.
module tb_pu_window_loader;

  logic        clk;
  logic        nrst;
  logic        go;
  logic [5:0]  num_rounds;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        pu_done;
  logic [15:0] new1;
  logic [4:0]  adrs_in1;
  logic [4:0]  adrs_in2;
  logic        wr_ctrl_g;
  logic        start;
  logic [5:0]  round;
  logic        busy;
  logic        done;

  pu_window_loader dut (
    .clk        (clk),
    .nrst       (nrst),
    .go         (go),
    .num_rounds (num_rounds),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .pu_done    (pu_done),
    .new1       (new1),
    .adrs_in1   (adrs_in1),
    .adrs_in2   (adrs_in2),
    .wr_ctrl_g  (wr_ctrl_g),
    .start      (start),
    .round      (round),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  int total = 0;
  int bad   = 0;

  // Model: expected register-file writes in order, expected round index per
  // launch, and what the write port must hold between writes.
  wr_t        m_q[$];
  logic [5:0] r_q[$];
  logic [4:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic       prev_wr  = 1'b0;
  logic       exp_done = 1'b0;
  logic       rst_seen = 1'b0;
  int         wr_count = 0;
  int         start_count = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(posedge clk) rst_seen <= nrst;

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    wr_t w;
    if (rst_seen) begin
      chk("reset_outs", {s_ready, wr_ctrl_g, start, busy, done, new1, adrs_in1, adrs_in2, round}, 64'd0);
      m_q.delete();
      r_q.delete();
      last_addr = '0;
      last_data = '0;
      prev_wr   = 1'b0;
      exp_done  = 1'b0;
    end else begin
      if (wr_ctrl_g) begin
        if (m_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          w = m_q.pop_front();
          chk("wr_addr", adrs_in1, w.a);
          chk("wr_data", new1, w.d);
          chk("rb_addr", adrs_in2, last_addr);
          last_addr = w.a;
          last_data = w.d;
        end
        wr_count++;
      end else begin
        chk("hold_new1", new1, last_data);
        chk("hold_addr", adrs_in1, last_addr);
      end
      if (start) begin
        chk("start_after_write", prev_wr, 1'b1);
        chk("start_all_written", m_q.size(), 64'd0);
        if (r_q.size() == 0) chk("unexpected_start", 64'd1, 64'd0);
        else chk("start_round", round, r_q.pop_front());
        start_count++;
      end
      if (s_ready) chk("ready_needs_busy", busy, 1'b1);
      if (done) begin
        chk("done_expected", exp_done, 1'b1);
        exp_done = 1'b0;
      end
      prev_wr = wr_ctrl_g;
    end
  end

  task automatic begin_row(input logic [5:0] n);
    num_rounds = n;
    go = 1'b1;
    r_q.push_back(6'd0);
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // Streams n words; gap>0 inserts that many idle cycles before each odd word.
  task automatic stream(input int n, input logic [4:0] abase, input logic [15:0] dbase,
                        input int gap, input int pd_idx);
    for (int i = 0; i < n; i++) begin
      bit  acc;
      int  cyc;
      wr_t w;
      if (gap > 0 && (i % 2) == 1) begin
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = dbase + 16'(i);
      pu_done = (i == pd_idx);
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 40) begin
        @(negedge clk);
        if (s_ready) begin
          acc = 1'b1;
          w.a = abase + 5'(i);
          w.d = dbase + 16'(i);
          m_q.push_back(w);
        end
        @(posedge clk); #1;
        cyc++;
      end
      pu_done = 1'b0;
      if (!acc) chk("beat_timeout", 64'd0, 64'd1);
    end
    s_valid = 1'b0;
  endtask

  task automatic run_round(input int delay, input bit last, input bit early_pd, input bit mid_go);
    bit found;
    int cyc;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 20) begin
      @(negedge clk);
      if (start) found = 1'b1;
      cyc++;
    end
    if (!found) chk("start_timeout", 64'd0, 64'd1);
    if (early_pd) pu_done = 1'b1;
    @(posedge clk); #1;
    pu_done = 1'b0;
    if (early_pd) begin
      @(negedge clk);
      chk("pd_at_start_ignored", {busy, done, s_ready}, 3'b100);
      @(posedge clk); #1;
    end
    if (mid_go) begin
      go = 1'b1;
      num_rounds = 6'd7;
      @(posedge clk); #1;
      go = 1'b0;
      @(negedge clk);
      chk("go_in_wait_ignored", {busy, s_ready, wr_ctrl_g, start}, 4'b1000);
      @(posedge clk); #1;
    end
    repeat (delay) begin @(posedge clk); #1; end
    exp_done = last;
    pu_done = 1'b1;
    @(posedge clk); #1;
    pu_done = 1'b0;
    @(negedge clk);
    if (last) begin
      chk("done_pulse", done, 1'b1);
      @(negedge clk);
      chk("idle_after_done", {busy, done}, 2'b00);
    end else begin
      chk("col_ready", {busy, s_ready, done}, 3'b110);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int w0;
    int s0;
    nrst = 1'b1;
    go = 1'b0;
    num_rounds = '0;
    s_data = 16'hDEAD;
    s_valid = 1'b1;
    pu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("idle_outs", {s_ready, busy, wr_ctrl_g, start, done}, 5'b0);
    @(posedge clk); #1;

    // Single round, back-to-back full window.
    w0 = wr_count; s0 = start_count;
    begin_row(6'd1);
    stream(25, 5'd0, 16'h0100, 0, -1);
    run_round(4, 1'b1, 1'b0, 1'b0);
    chk("t1_writes", wr_count - w0, 64'd25);
    chk("t1_starts", start_count - s0, 64'd1);

    // Three rounds: full window then two column refreshes.
    w0 = wr_count; s0 = start_count;
    begin_row(6'd3);
    stream(25, 5'd0, 16'h0100, 0, -1);
    run_round(2, 1'b0, 1'b1, 1'b0);
    r_q.push_back(6'd1);
    stream(5, 5'd20, 16'h0210, 0, -1);
    run_round(1, 1'b0, 1'b0, 1'b1);
    r_q.push_back(6'd2);
    stream(5, 5'd20, 16'h0220, 0, -1);
    run_round(1, 1'b1, 1'b0, 1'b0);
    chk("t2_writes", wr_count - w0, 64'd35);
    chk("t2_starts", start_count - s0, 64'd3);

    // Stalled stream with a stray pu_done mid-load.
    w0 = wr_count;
    begin_row(6'd1);
    stream(25, 5'd0, 16'h0500, 2, 10);
    run_round(3, 1'b1, 1'b0, 1'b0);
    chk("t3_writes", wr_count - w0, 64'd25);

    // num_rounds of zero runs exactly one round.
    w0 = wr_count; s0 = start_count;
    begin_row(6'd0);
    stream(25, 5'd0, 16'h0300, 0, -1);
    run_round(2, 1'b1, 1'b0, 1'b0);
    chk("t4_writes", wr_count - w0, 64'd25);
    chk("t4_starts", start_count - s0, 64'd1);

    // Reset after write 12, then a clean restart.
    begin_row(6'd2);
    stream(12, 5'd0, 16'h0400, 0, -1);
    nrst = 1'b1;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {s_ready, wr_ctrl_g, start, busy, done, adrs_in1, adrs_in2, round}, 64'd0);
    @(posedge clk); #1;
    w0 = wr_count; s0 = start_count;
    begin_row(6'd1);
    stream(25, 5'd0, 16'h0600, 0, -1);
    run_round(1, 1'b1, 1'b0, 1'b0);
    chk("t5_writes", wr_count - w0, 64'd25);
    chk("t5_starts", start_count - s0, 64'd1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pu_window_loader.md
Name: pu_window_loader

Overview:
- Write-side feeder for one img2col processing unit (PU): takes pixel words from the AXI-side stream, drives the PU's 25-entry new-data register file (write enable, addresses, data), then launches each round.
- Round 0 of a row loads the full 5x5 window (25 words). Every later round loads only the new 5-word column; the PU keeps the other 20 words in its reserved register bank.
- Waits for the PU's neighbour_out_flag before loading the next round. Sits between the AXI read path and the PU, one instance per PU.

Parameters:
- data_width, 16, pixel word width
- weight_size, 25, words in a full window (kernel 5x5)
- col_size, 5, words in one new window column
- address_num, 5, register-file address width
- round_width, 6, width of round index / round count

Ports:
- clk  in  1  clock
- nrst  in  1  reset. Asserted HIGH; port name kept for codebase consistency.
- go  in  1  one-cycle pulse that starts a row of rounds; sampled only in IDLE
- num_rounds  in  round_width  rounds in this row; latched on go; 0 is treated as 1
- s_data  in  data_width  pixel word from the AXI side
- s_valid  in  1  s_data valid
- s_ready  out  1  loader accepts s_data this cycle
- pu_done  in  1  connect to PU neighbour_out_flag; PU finished the current round
- new1  out  data_width  write data to the PU register file
- adrs_in1  out  address_num  write address
- adrs_in2  out  address_num  read-back address: the previous write address
- wr_ctrl_g  out  1  register-file write enable
- start  out  1  one-cycle round launch pulse to the PU
- round  out  round_width  current round index, stable from start until the next load
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last round's pu_done

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (nrst high at a posedge):
  - state becomes IDLE.
  - All outputs are 0: s_ready, new1, adrs_in1, adrs_in2, wr_ctrl_g, start, round, busy, done.
  - Internal counters are cleared.
  - Reset mid-load or mid-wait aborts the row. There is no partial resume.
- States: IDLE, FULL_LOAD, COL_LOAD, LAUNCH, WAIT_PU, FINISH.
- IDLE:
  - s_ready=0.
  - On go: latch max(num_rounds,1), set round=0, set word counter=0, go to FULL_LOAD.
  - go in any other state is ignored.
- FULL_LOAD:
  - s_ready=1.
  - Each beat (s_valid && s_ready) registers new1=s_data, adrs_in1=counter, wr_ctrl_g=1 on the next cycle. Latency from beat to write is 1 cycle.
  - A cycle without a beat gives wr_ctrl_g=0, with new1 and adrs_in1 held.
  - After beat 25 (counter 24): s_ready drops in the same cycle's next state; go to LAUNCH.
- COL_LOAD:
  - Same beat rule, with addresses 20..24 (weight_size-col_size upward), 5 beats.
  - After the 5th beat, go to LAUNCH.
- LAUNCH:
  - Entered the cycle after the final write is presented, so the final wr_ctrl_g pulse precedes start by exactly one cycle.
  - start=1 for one cycle, round=current index, s_ready=0. Then go to WAIT_PU.
- WAIT_PU:
  - s_ready=0.
  - On pu_done: if round == latched_rounds-1, go to FINISH. Otherwise round+1, counter reset, go to COL_LOAD.
  - pu_done seen in any state other than WAIT_PU is ignored.
- FINISH: done=1 for one cycle, then IDLE.
- adrs_in2 is the registered copy of adrs_in1, updated only on writes. It is 0 after reset.
- The word counter never wraps past 24. The round counter saturates at latched_rounds-1.
- pu_done on the same cycle as start cannot be counted: WAIT_PU begins the cycle after start.

Decomposition:
- Shared package pu_pkg holds:
  - the state enum
  - constants WEIGHT_SIZE=25, COL_SIZE=5, COL_BASE_ADDR=20
  - DATA_WIDTH and ADDR_WIDTH defaults
- No sub-module. A single FSM with a word counter and a round counter is sufficient.

Test Plan:
- Reset then idle: hold nrst high 3 cycles, s_valid=1 -> all outputs 0, s_ready=0, no wr_ctrl_g.
- Full load: go with num_rounds=1, stream 25 words 0x0100..0x0118 back-to-back -> wr_ctrl_g high 25 cycles with adrs_in1 0..24 and matching new1; start one cycle after the last write with round=0; pu_done 4 cycles later -> done pulse, then IDLE.
- Multi-round: num_rounds=3 -> 25 writes, start(round 0); pu_done; 5 writes at addresses 20..24, start(round 1); pu_done; 5 writes, start(round 2); pu_done -> done. Total 35 writes.
- Stalls: during FULL_LOAD toggle s_valid 1,0,0,1,... -> wr_ctrl_g only on accepted beats, addresses still contiguous, new1 held on gaps, total 25 writes.
- Edge inputs: num_rounds=0 behaves as 1; go pulsed during WAIT_PU -> ignored; pu_done pulsed during FULL_LOAD -> ignored; start fires only after write 25.
- Reset mid-operation: assert nrst at write 12 of round 0 -> next cycle all outputs 0 and state IDLE; a fresh go restarts at adrs_in1=0, round=0.
